// File: rtl/key_scan_debounce_ctrl_pkg.sv
// Shared types and constants for the key scan debounce controller.
// Holds the FSM encoding, default timing parameters and a constant clog2 helper.
package key_scan_debounce_ctrl_pkg;

   typedef enum logic {
      ST_WAIT = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   localparam int TICK_DIV_DEF       = 50000;
   localparam int STABLE_SAMPLES_DEF = 4;

   // Smallest r with 2**r >= v; returns 0 for v <= 1.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/key_scan_debounce_ctrl_key_sync.sv
// Two-flop synchronizer for a bank of asynchronous key inputs.
// Output lags the input by two clock cycles; both stages reset to 0.
module key_sync #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= '0;
         dout <= '0;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/key_scan_debounce_ctrl.sv
// Time-shared key debouncer: a prescaler paces scan passes, and each pass
// visits one key per cycle to update its stability counter and clean level.
module key_scan_debounce_ctrl
   import key_scan_debounce_ctrl_pkg::*;
#(
   parameter int N_KEYS         = 4,
   parameter int TICK_DIV       = TICK_DIV_DEF,
   parameter int STABLE_SAMPLES = STABLE_SAMPLES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic              scan_busy
);

   localparam int CNT_W = clog2(STABLE_SAMPLES + 1);
   localparam int PRE_W = (TICK_DIV > 1) ? clog2(TICK_DIV) : 1;
   localparam int IDX_W = (N_KEYS > 1) ? clog2(N_KEYS) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_KEYS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

   state_t            state, state_nxt;
   logic [PRE_W-1:0]  pre, pre_nxt;
   logic [IDX_W-1:0]  idx, idx_nxt;
   logic [N_KEYS-1:0] sync_q;
   logic [CNT_W-1:0]  cnt [N_KEYS];

   key_sync #(
      .W(N_KEYS)
   ) u_key_sync (
      .clk  (clk),
      .reset(reset),
      .din  (key_in),
      .dout (sync_q)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_WAIT;
         pre   <= '0;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         pre   <= pre_nxt;
         idx   <= idx_nxt;
      end
   end

   // enable only gates the start of a pass; an active pass always runs to the last key.
   always_comb begin
      state_nxt = state;
      pre_nxt   = pre;
      idx_nxt   = idx;
      case (state)
         ST_WAIT: begin
            if (!enable) begin
               pre_nxt = '0;
            end else if (pre == PRE_LAST) begin
               state_nxt = ST_SCAN;
               pre_nxt   = '0;
               idx_nxt   = '0;
            end else begin
               pre_nxt = pre + PRE_W'(1);
            end
         end
         ST_SCAN: begin
            if (idx == IDX_LAST) begin
               state_nxt = ST_WAIT;
               pre_nxt   = '0;
               idx_nxt   = '0;
            end else begin
               idx_nxt = idx + IDX_W'(1);
            end
         end
         default: state_nxt = ST_WAIT;
      endcase
   end

   always_comb begin
      scan_busy = (state == ST_SCAN);
   end

   // Only the key under idx is touched; a sample matching the level clears its counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_level   <= '0;
         key_press   <= '0;
         key_release <= '0;
         for (int i = 0; i < N_KEYS; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         key_press   <= '0;
         key_release <= '0;
         if (state == ST_SCAN) begin
            if (sync_q[idx] == key_level[idx]) begin
               cnt[idx] <= '0;
            end else if (cnt[idx] == CNT_LAST) begin
               key_level[idx] <= sync_q[idx];
               cnt[idx]       <= '0;
               if (sync_q[idx]) begin
                  key_press[idx] <= 1'b1;
               end else begin
                  key_release[idx] <= 1'b1;
               end
            end else begin
               cnt[idx] <= cnt[idx] + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_key_scan_debounce_ctrl.sv
// Bench for key_scan_debounce_ctrl with N_KEYS=4, TICK_DIV=8, STABLE_SAMPLES=3.
// Expected values come from a pass-phase arithmetic model and a stimulus table.
module tb_key_scan_debounce_ctrl;

   localparam int NK     = 4;
   localparam int TDIV   = 8;
   localparam int STABLE = 3;
   localparam int PERIOD = TDIV + NK;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b0;
   logic [NK-1:0] key_in = '0;
   logic [NK-1:0] key_level;
   logic [NK-1:0] key_press;
   logic [NK-1:0] key_release;
   logic          scan_busy;

   int checks = 0;
   int failures = 0;

   key_scan_debounce_ctrl #(
      .N_KEYS        (NK),
      .TICK_DIV      (TDIV),
      .STABLE_SAMPLES(STABLE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .key_in     (key_in),
      .key_level  (key_level),
      .key_press  (key_press),
      .key_release(key_release),
      .scan_busy  (scan_busy)
   );

   // clock / reset block
   always #5 clk = ~clk;

   // reference model state: edges counted since reset release, input history per edge
   int            e;
   bit            model_on;
   logic [NK-1:0] in_hist [0:4095];
   int            mcnt [NK];
   logic [NK-1:0] mlevel, mpress, mrel;

   typedef struct {
      logic [NK-1:0] key;
      int            passes;
      logic [NK-1:0] exp_level;
      logic [NK-1:0] exp_press;
      logic [NK-1:0] exp_rel;
   } vec_t;

   vec_t          tbl [11];
   logic [NK-1:0] exp_q [$];
   logic [NK-1:0] press_acc, rel_acc;
   int            pulse_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, exp, e);
      end
   endtask

   // A key is sampled in the cycle after edge p when p >= TDIV and p mod PERIOD >= TDIV;
   // the synchronizer makes that sample equal to key_in as seen at edge p-1.
   task automatic model_edge();
      int p, k;
      logic s;
      mpress = '0;
      mrel   = '0;
      p = e - 1;
      if (p >= TDIV && (p % PERIOD) >= TDIV) begin
         k = (p % PERIOD) - TDIV;
         s = in_hist[e-2][k];
         if (s == mlevel[k]) begin
            mcnt[k] = 0;
         end else if (mcnt[k] + 1 == STABLE) begin
            mlevel[k] = s;
            mcnt[k]   = 0;
            if (s) mpress[k] = 1'b1;
            else   mrel[k]   = 1'b1;
         end else begin
            mcnt[k] = mcnt[k] + 1;
         end
      end
   endtask

   task automatic step();
      logic exp_busy;
      @(posedge clk);
      e++;
      in_hist[e] = key_in;
      if (model_on) model_edge();
      @(negedge clk);
      if (model_on) begin
         exp_busy = (e >= TDIV) && ((e % PERIOD) >= TDIV);
         check("model_level", key_level, mlevel);
         check("model_press", key_press, mpress);
         check("model_release", key_release, mrel);
         check("model_busy", scan_busy, exp_busy);
      end
      if ((key_press | key_release) != '0) begin
         check("one_pulse_bit", $countones(key_press | key_release), 1);
      end
   endtask

   task automatic do_reset(input int n, input logic [NK-1:0] kin);
      reset  = 1'b1;
      key_in = 4'hF;
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         check("rst_level", key_level, 0);
         check("rst_press", key_press, 0);
         check("rst_release", key_release, 0);
         check("rst_busy", scan_busy, 0);
      end
      key_in = kin;
      reset  = 1'b0;
      e      = 0;
      mlevel = '0;
      mpress = '0;
      mrel   = '0;
      for (int i = 0; i < NK; i++) mcnt[i] = 0;
      model_on = 1'b1;
   endtask

   initial begin
      bit found;
      tbl[0]  = '{4'b0000, 1, 4'b0000, 4'b0000, 4'b0000};
      tbl[1]  = '{4'b0100, 3, 4'b0100, 4'b0100, 4'b0000};
      tbl[2]  = '{4'b0110, 2, 4'b0100, 4'b0000, 4'b0000};
      tbl[3]  = '{4'b0100, 1, 4'b0100, 4'b0000, 4'b0000};
      tbl[4]  = '{4'b0110, 2, 4'b0100, 4'b0000, 4'b0000};
      tbl[5]  = '{4'b0110, 1, 4'b0110, 4'b0010, 4'b0000};
      tbl[6]  = '{4'b0010, 3, 4'b0010, 4'b0000, 4'b0100};
      tbl[7]  = '{4'b0000, 3, 4'b0000, 4'b0000, 4'b0010};
      tbl[8]  = '{4'b1111, 3, 4'b1111, 4'b1111, 4'b0000};
      tbl[9]  = '{4'b0000, 2, 4'b1111, 4'b0000, 4'b0000};
      tbl[10] = '{4'b0000, 1, 4'b0000, 4'b0000, 4'b1111};

      // reset with all keys high, then the scan cadence is checked by the model
      enable = 1'b1;
      do_reset(5, 4'h0);
      repeat (3 * PERIOD) step();

      // table-driven sequence, each row starts right after a pass ends
      do_reset(2, 4'h0);
      for (int r = 0; r < 11; r++) begin
         key_in    = tbl[r].key;
         press_acc = '0;
         rel_acc   = '0;
         pulse_cnt = 0;
         repeat (tbl[r].passes * PERIOD) begin
            step();
            press_acc |= key_press;
            rel_acc   |= key_release;
            pulse_cnt += $countones(key_press) + $countones(key_release);
         end
         check($sformatf("row%0d_level", r), key_level, tbl[r].exp_level);
         check($sformatf("row%0d_press", r), press_acc, tbl[r].exp_press);
         check($sformatf("row%0d_release", r), rel_acc, tbl[r].exp_rel);
         check($sformatf("row%0d_pulse_cnt", r), pulse_cnt,
               $countones(tbl[r].exp_press) + $countones(tbl[r].exp_rel));
      end

      // simultaneous press: pulses in ascending key order on consecutive cycles
      do_reset(2, 4'hF);
      exp_q = '{4'h1, 4'h2, 4'h4, 4'h8};
      for (int c = 0; c < 3 * PERIOD; c++) begin
         step();
         if (key_press != '0) begin
            if (exp_q.size() == 0) begin
               check("simul_extra_press", key_press, 0);
            end else begin
               check("simul_press_order", key_press, exp_q.pop_front());
            end
         end else if (exp_q.size() inside {[1:3]}) begin
            check("simul_press_gap", key_press, exp_q[0]);
         end
      end
      check("simul_missing", exp_q.size(), 0);
      check("simul_level", key_level, 4'hF);

      // enable low: no passes, level frozen while inputs toggle
      model_on = 1'b0;
      enable   = 1'b0;
      for (int c = 0; c < 48; c++) begin
         key_in = 4'($urandom_range(0, 15));
         step();
         check("dis_busy", scan_busy, 0);
         check("dis_level", key_level, 4'hF);
      end

      // enable dropped in the first SCAN cycle: the pass still completes
      key_in = 4'hF;
      enable = 1'b1;
      found  = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         step();
         found = scan_busy;
      end
      check("en_scan_start", found, 1);
      enable = 1'b0;
      repeat (NK - 1) begin
         step();
         check("en_pass_completes", scan_busy, 1);
      end
      repeat (20) begin
         step();
         check("en_stays_idle", scan_busy, 0);
      end

      // reset while a press pulse is pending mid-pass
      enable = 1'b1;
      do_reset(1, 4'hF);
      found = 1'b0;
      for (int c = 0; c < 4 * PERIOD && !found; c++) begin
         step();
         found = (key_press != '0);
      end
      check("midscan_pulse_seen", found, 1);
      check("midscan_busy_before", scan_busy, 1);
      reset = 1'b1;
      #1;
      check("async_rst_level", key_level, 0);
      check("async_rst_press", key_press, 0);
      check("async_rst_release", key_release, 0);
      check("async_rst_busy", scan_busy, 0);
      @(negedge clk);
      do_reset(1, 4'hF);
      repeat (2 * PERIOD) step();

      // randomized keys with occasional flips, checked every cycle by the model
      do_reset(2, 4'h0);
      for (int c = 0; c < 60 * PERIOD; c++) begin
         for (int k = 0; k < NK; k++) begin
            if ($urandom_range(0, 39) == 0) key_in[k] = ~key_in[k];
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
